// File: rtl/bnn_pkg.sv
// Shared BNN dimensions and the pooling/flatten FSM state encoding.
// The final layer derives its NUM_INPUTS default from FLAT_LEN.
package bnn_pkg;
  localparam int IMG_W    = 28;
  localparam int IMG_H    = 28;
  localparam int POOLED_W = IMG_W / 2;
  localparam int FLAT_LEN = POOLED_W * (IMG_H / 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;
endpackage

// File: rtl/pool_row_or2x2.sv
// Combinational 2x2 binary max-pool of two adjacent rows: each output bit
// is the OR of a 2x2 window.
module pool_row_or2x2 #(
  parameter int IMG_W = bnn_pkg::IMG_W
) (
  input  logic [IMG_W-1:0]   row_a,
  input  logic [IMG_W-1:0]   row_b,
  output logic [IMG_W/2-1:0] pooled
);
  for (genvar c = 0; c < IMG_W/2; c++) begin : g_win
    assign pooled[c] = row_a[2*c] | row_a[2*c+1] | row_b[2*c] | row_b[2*c+1];
  end
endmodule

// File: rtl/maxpool_flatten_layer.sv
// Collects a binary feature map row by row, 2x2 OR-pools row pairs and
// assembles the flattened vector consumed by the final classification layer.
module maxpool_flatten_layer
  import bnn_pkg::*;
#(
  parameter int IMG_W = bnn_pkg::IMG_W,
  parameter int IMG_H = bnn_pkg::IMG_H,
  localparam int NUM_OUTPUTS = (IMG_W/2) * (IMG_H/2)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   row_valid,
  input  logic [IMG_W-1:0]       row_in,
  output logic                   row_ready,
  output logic [NUM_OUTPUTS-1:0] data_out,
  output logic                   layer_2_done
);
  localparam int PW    = IMG_W / 2;
  localparam int CNT_W = $clog2(IMG_H);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);

  state_t           state;
  logic [CNT_W-1:0] row_cnt;
  logic [IMG_W-1:0] row_buf;
  logic [PW-1:0]    pooled;
  logic             accept;

  // Even row sits in row_buf; the odd row arrives live on row_in.
  pool_row_or2x2 #(.IMG_W(IMG_W)) u_pool (
    .row_a (row_buf),
    .row_b (row_in),
    .pooled(pooled)
  );

  assign accept = row_valid && row_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      row_cnt      <= '0;
      row_buf      <= '0;
      data_out     <= '0;
      row_ready    <= 1'b0;
      layer_2_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          layer_2_done <= 1'b0;
          row_ready    <= 1'b0;
          if (en) begin
            state     <= COLLECT;
            data_out  <= '0;
            row_cnt   <= '0;
            row_ready <= 1'b1;
          end
        end
        COLLECT: begin
          if (!en) begin
            // Abandoned frame: nothing partial may leak into the next one.
            state     <= IDLE;
            data_out  <= '0;
            row_cnt   <= '0;
            row_ready <= 1'b0;
          end else if (accept) begin
            if (!row_cnt[0])
              row_buf <= row_in;
            else
              data_out[int'(row_cnt >> 1) * PW +: PW] <= pooled;
            if (row_cnt == LAST_ROW) begin
              state        <= DONE;
              row_cnt      <= '0;
              row_ready    <= 1'b0;
              layer_2_done <= 1'b1;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          row_ready <= 1'b0;
          if (!en) begin
            state        <= IDLE;
            layer_2_done <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          row_ready    <= 1'b0;
          layer_2_done <= 1'b0;
        end
      endcase
    end
  end
endmodule
